ws2812_frame_ctrl: RTL and testbench

- Frame scheduler and pixel store for the ws2812 NeoPixel serializer.
- Holds a double-buffered pixel RAM. The host (SPI side) writes the back bank and commits it; the controller swaps banks only at a frame boundary.
- Pulses the serializer's start input on each commit, and optionally on a periodic refresh timer.
- Answers the serializer's data requests with pixel data. Sits between the SPI register layer and ws2812.

---
 rtl/ws2812_pkg.sv | 47 ++++
 rtl/ws2812_pixel_ram.sv | 52 +++++
 rtl/ws2812_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared types and helpers for the ws2812 frame controller slice.
//   state_t        : frame scheduler states
//   pixel_t        : one packed pixel, {green, red, blue}
//   *_LSB          : bit offsets of each colour inside a packed pixel
//   refresh_cycles : clock cycles between periodic re-sends
//   scale_colour   : brightness scaling used when
//                    WS2812_FRAME_CTRL_BRIGHTNESS_EN is defined
// ---------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    localparam int COLOUR_W  = 8;
    localparam int GREEN_LSB = 16;
    localparam int RED_LSB   = 8;
    localparam int BLUE_LSB  = 0;

    // A zero or negative rate would divide by zero; fall back to one cycle.
    function automatic int refresh_cycles(input int sys_clk, input int hz);
        int cycles;
        cycles = (hz > 0) ? (sys_clk / hz) : 1;
        return (cycles < 1) ? 1 : cycles;
    endfunction

    // (raw * (brightness + 1)) >> 8; brightness 255 returns raw unchanged.
    // The product never exceeds 255 * 256, so 16 bits hold it exactly.
    function automatic logic [7:0] scale_colour(input logic [7:0] raw,
                                                input logic [7:0] brightness);
        logic [15:0] prod;
        prod = 16'(raw) * (16'(brightness) + 16'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// ---------------------------------------------------------------------------
// ws2812_pixel_ram
// Simple dual-port pixel store holding both banks. The bank select is the
// MSB of each address, so the caller forms {bank, index}.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset (read register only)
//   wr_en_i         : write strobe
//   wr_addr_i       : {bank, index} write address
//   wr_data_i       : pixel to store
//   rd_en_i         : read strobe; read data updates the following cycle
//   rd_addr_i       : {bank, index} read address
//   rd_data_o       : registered read data, holds when rd_en_i is low
// ---------------------------------------------------------------------------
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            wr_en_i,
    input  logic [ADDR_W:0] wr_addr_i,
    input  pixel_t          wr_data_i,
    input  logic            rd_en_i,
    input  logic [ADDR_W:0] rd_addr_i,
    output pixel_t          rd_data_o
);

    // Sized by the full {bank, index} space so a non power-of-two LED count
    // still maps bank 1 without aliasing; equals 2*NUM_LEDS otherwise.
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    pixel_t mem [DEPTH];

    // Storage array is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the read register is reset, which is what gives the serializer
    // zero colour data straight after reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ws2812_frame_ctrl
// Frame scheduler and double-buffered pixel store in front of the ws2812
// serializer. The host fills the back bank and commits; banks swap only
// while idle, so a frame in flight never sees mixed data.
// Ports:
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   wr_en_i/wr_addr_i/wr_data_i : host pixel write into the back bank
//   commit_i                 : back bank complete, swap at next frame boundary
//   refresh_en_i             : re-send the front bank periodically
//   led_count_i              : LEDs per frame (0 swaps banks but sends nothing)
//   drv_start_o              : one-cycle start pulse to the serializer
//   drv_busy_i               : serializer busy
//   drv_data_request_i/drv_address_i : serializer pixel fetch
//   drv_red_o/drv_green_o/drv_blue_o : pixel data, valid the cycle after a request
//   drv_led_count_o          : LED count latched for the current frame
//   commit_pending_o         : a commit is waiting for a swap
//   frame_count_o            : completed frames, wraps
//   brightness_i             : only with WS2812_FRAME_CTRL_BRIGHTNESS_EN
// Build option: define WS2812_FRAME_CTRL_BRIGHTNESS_EN to scale colours.
// ---------------------------------------------------------------------------
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50_000_000,
    parameter int REFRESH_HZ   = 30,
    localparam int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [23:0]       wr_data_i,
    input  logic              commit_i,
    input  logic              refresh_en_i,
    input  logic [ADDR_W-1:0] led_count_i,
`ifdef WS2812_FRAME_CTRL_BRIGHTNESS_EN
    input  logic [7:0]        brightness_i,
`endif
    output logic              drv_start_o,
    input  logic              drv_busy_i,
    input  logic              drv_data_request_i,
    input  logic [ADDR_W-1:0] drv_address_i,
    output logic [7:0]        drv_red_o,
    output logic [7:0]        drv_green_o,
    output logic [7:0]        drv_blue_o,
    output logic [ADDR_W-1:0] drv_led_count_o,
    output logic              commit_pending_o,
    output logic [15:0]       frame_count_o
);

    localparam int          REFRESH_CYCLES = refresh_cycles(SYSTEM_CLOCK, REFRESH_HZ);
    localparam logic [31:0] REFRESH_LAST   = 32'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_W:0] LED_LIMIT  = (ADDR_W + 1)'(NUM_LEDS);

    state_t      state;
    logic        front;
    logic        pending;
    logic [31:0] refresh_cnt;
    logic        refresh_expired;
    logic        swap;
    logic        wr_in_range;
    logic        rd_in_range;
    logic        rd_valid;
    pixel_t      rd_pixel;
    logic [23:0] shown;

    assign refresh_expired  = (refresh_cnt == REFRESH_LAST);
    assign swap             = (state == IDLE) && pending;
    assign commit_pending_o = pending;
    assign wr_in_range      = {1'b0, wr_addr_i} < LED_LIMIT;
    assign rd_in_range      = {1'b0, drv_address_i} < LED_LIMIT;

    ws2812_pixel_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (wr_en_i && wr_in_range),
        .wr_addr_i ({~front, wr_addr_i}),
        .wr_data_i (pixel_t'(wr_data_i)),
        .rd_en_i   (drv_data_request_i),
        .rd_addr_i ({front, drv_address_i}),
        .rd_data_o (rd_pixel)
    );

    // Frame scheduler. The front bank only toggles on the IDLE->START
    // transition, which is what keeps a frame tear-free. A commit landing in
    // the swap cycle re-arms pending because commit_i wins over the clear.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state           <= IDLE;
            front           <= 1'b0;
            pending         <= 1'b0;
            refresh_cnt     <= '0;
            frame_count_o   <= '0;
            drv_start_o     <= 1'b0;
            drv_led_count_o <= '0;
        end else begin
            drv_start_o <= 1'b0;
            pending     <= commit_i | (pending & ~swap);
            if (!refresh_expired) begin
                refresh_cnt <= refresh_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        front       <= ~front;
                        refresh_cnt <= '0;
                        state       <= START;
                    end else if (refresh_en_i && refresh_expired) begin
                        refresh_cnt <= '0;
                        state       <= START;
                    end
                end
                START: begin
                    drv_led_count_o <= led_count_i;
                    if (led_count_i == '0) begin
                        state <= IDLE;
                    end else begin
                        drv_start_o <= 1'b1;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (drv_busy_i) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!drv_busy_i) begin
                        frame_count_o <= frame_count_o + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember whether the last request addressed a real LED so that
    // out-of-range fetches read back as black and hold like real data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_valid <= 1'b0;
        end else if (drv_data_request_i) begin
            rd_valid <= rd_in_range;
        end
    end

    assign shown = rd_valid ? 24'(rd_pixel) : 24'd0;

`ifdef WS2812_FRAME_CTRL_BRIGHTNESS_EN
    assign drv_green_o = scale_colour(shown[GREEN_LSB +: COLOUR_W], brightness_i);
    assign drv_red_o   = scale_colour(shown[RED_LSB   +: COLOUR_W], brightness_i);
    assign drv_blue_o  = scale_colour(shown[BLUE_LSB  +: COLOUR_W], brightness_i);
`else
    assign drv_green_o = shown[GREEN_LSB +: COLOUR_W];
    assign drv_red_o   = shown[RED_LSB   +: COLOUR_W];
    assign drv_blue_o  = shown[BLUE_LSB  +: COLOUR_W];
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ws2812_frame_ctrl
// Directed bench for ws2812_frame_ctrl with a behavioural serializer.
// Expected pixels are queued as each frame is scheduled; a separate monitor
// pops and compares whenever the serializer's fetched data becomes valid.
// Uses NUM_LEDS=6 (so addresses 6/7 are out of range) and a 1000-cycle
// refresh period.
// ---------------------------------------------------------------------------
module tb_ws2812_frame_ctrl;

    localparam int AW = 3;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          commit;
    logic          refresh_en;
    logic [AW-1:0] led_count;
    logic          drv_start;
    logic          drv_busy;
    logic          drv_req;
    logic [AW-1:0] drv_addr;
    logic [7:0]    drv_red;
    logic [7:0]    drv_green;
    logic [7:0]    drv_blue;
    logic [AW-1:0] drv_led_count;
    logic          pending;
    logic [15:0]   frame_count;
`ifdef WS2812_FRAME_CTRL_BRIGHTNESS_EN
    logic [7:0]    brightness;
`endif

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            start_pulses = 0;
    int            cycle        = 0;
    int            start_times[$];
    logic [23:0]   exp_q[$];

    int            ser_base      = 0;
    int            ser_hold      = 4;
    bit            ser_skip_reads = 1'b0;

    ws2812_frame_ctrl #(
        .NUM_LEDS     (6),
        .SYSTEM_CLOCK (1000),
        .REFRESH_HZ   (1)
    ) dut (
        .clk_i              (clk),
        .reset_ni           (reset_n),
        .wr_en_i            (wr_en),
        .wr_addr_i          (wr_addr),
        .wr_data_i          (wr_data),
        .commit_i           (commit),
        .refresh_en_i       (refresh_en),
        .led_count_i        (led_count),
`ifdef WS2812_FRAME_CTRL_BRIGHTNESS_EN
        .brightness_i       (brightness),
`endif
        .drv_start_o        (drv_start),
        .drv_busy_i         (drv_busy),
        .drv_data_request_i (drv_req),
        .drv_address_i      (drv_addr),
        .drv_red_o          (drv_red),
        .drv_green_o        (drv_green),
        .drv_blue_o         (drv_blue),
        .drv_led_count_o    (drv_led_count),
        .commit_pending_o   (pending),
        .frame_count_o      (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Count start pulses and remember when each one was seen.
    always @(negedge clk) begin
        if (drv_start) begin
            start_pulses++;
            start_times.push_back(cycle);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [23:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic commitFrame();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        for (int i = 0; i < budget && frame_count != 16'(target); i++) @(negedge clk);
        checkOutput("frame_count", 32'(frame_count), 32'(target));
    endtask

    task automatic waitBusy(input int budget);
        for (int i = 0; i < budget && !drv_busy; i++) @(negedge clk);
        checkOutput("serializer started", 32'(drv_busy), 32'd1);
    endtask

    // Behavioural serializer: on a start pulse go busy, fetch the latched
    // number of pixels from ser_base upward, linger, then drop busy.
    initial begin
        int cnt;
        drv_busy = 1'b0;
        drv_req  = 1'b0;
        drv_addr = '0;
        forever begin
            @(negedge clk);
            if (drv_start) begin
                cnt = int'(drv_led_count);
                repeat (2) @(negedge clk);
                drv_busy = 1'b1;
                if (!ser_skip_reads) begin
                    for (int i = 0; i < cnt; i++) begin
                        @(negedge clk);
                        drv_req  = 1'b1;
                        drv_addr = AW'(ser_base + i);
                        @(negedge clk);
                        drv_req  = 1'b0;
                    end
                end
                repeat (ser_hold) @(negedge clk);
                drv_busy = 1'b0;
            end
        end
    end

    // Monitor: data registered on a request edge is compared 1 time unit later.
    initial begin
        logic [23:0] expv;
        forever begin
            @(posedge clk);
            if (drv_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected pixel: got 0x%06h with nothing expected",
                             {drv_green, drv_red, drv_blue});
                end else begin
                    expv = exp_q.pop_front();
                    checkOutput("pixel", 32'({drv_green, drv_red, drv_blue}), 32'(expv));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [23:0] set_a [4];
        logic [23:0] set_b [4];
        logic [23:0] set_c [4];
        int s0;
        int ok;
        int iv;
        set_a = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        set_b = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
        set_c = '{24'hC0FFEE, 24'h123456, 24'hABCDEF, 24'h0F0F0F};

        reset_n    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        commit     = 1'b0;
        refresh_en = 1'b0;
        led_count  = '0;
`ifdef WS2812_FRAME_CTRL_BRIGHTNESS_EN
        brightness = 8'd255;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset drv_start", 32'(drv_start), 32'd0);
        checkOutput("reset colours", 32'({drv_green, drv_red, drv_blue}), 32'd0);
        checkOutput("reset led_count", 32'(drv_led_count), 32'd0);
        checkOutput("reset pending", 32'(pending), 32'd0);
        checkOutput("reset frame_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Frame 1: four pixels into bank 1, commit, serializer reads them back
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), set_a[i]);
        led_count = 3'd4;
        for (int i = 0; i < 4; i++) exp_q.push_back(set_a[i]);
        s0 = start_pulses;
        commitFrame();
        waitFrames(1, 200);
        checkOutput("frame1 start pulses", 32'(start_pulses - s0), 32'd1);
        checkOutput("frame1 pending", 32'(pending), 32'd0);
        checkOutput("frame1 led_count", 32'(drv_led_count), 32'd4);
        checkOutput("frame1 drained", 32'(exp_q.size()), 32'd0);

        // Commit while the serializer is busy: old bank is read to the end
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), set_b[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(set_b[i]);
        ser_hold = 30;
        s0 = start_pulses;
        commitFrame();
        waitBusy(50);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), set_c[i]);
        applyStimulus(3'd5, 24'h5A5A5A);
        for (int i = 0; i < 4; i++) exp_q.push_back(set_c[i]);
        commitFrame();
        checkOutput("pending after mid-frame commit", 32'(pending), 32'd1);
        checkOutput("no swap while busy", 32'(start_pulses - s0), 32'd1);
        waitFrames(3, 400);
        checkOutput("second start after swap", 32'(start_pulses - s0), 32'd2);
        checkOutput("pending cleared by swap", 32'(pending), 32'd0);
        checkOutput("frame2 drained", 32'(exp_q.size()), 32'd0);

        // led_count 0: bank swaps but nothing is sent
        ser_hold  = 4;
        led_count = 3'd0;
        s0 = start_pulses;
        commitFrame();
        repeat (10) @(negedge clk);
        checkOutput("zero-count start pulses", 32'(start_pulses - s0), 32'd0);
        checkOutput("zero-count frame_count", 32'(frame_count), 32'd3);
        checkOutput("zero-count pending", 32'(pending), 32'd0);
        checkOutput("zero-count led_count", 32'(drv_led_count), 32'd0);

        // Swap back to bank 1; address 6 is past NUM_LEDS and reads as zero
        led_count = 3'd2;
        ser_base  = 5;
        exp_q.push_back(24'h5A5A5A);
        exp_q.push_back(24'h000000);
        commitFrame();
        waitFrames(4, 200);
        checkOutput("range frame drained", 32'(exp_q.size()), 32'd0);

        // Periodic refresh re-sends the same front bank
        ser_base = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(set_c[0]);
            exp_q.push_back(set_c[1]);
        end
        s0 = start_pulses;
        refresh_en = 1'b1;
        for (int i = 0; i < 4000 && start_pulses < s0 + 3; i++) @(negedge clk);
        refresh_en = 1'b0;
        checkOutput("refresh start pulses", 32'(start_pulses - s0), 32'd3);
        for (int k = 1; k < 3; k++) begin
            iv = (start_times.size() >= s0 + 3) ? start_times[s0 + k] - start_times[s0 + k - 1] : 0;
            ok = (iv >= 1000 && iv <= 1100) ? 1 : 0;
            tests_run++;
            if (ok == 0) begin
                tests_failed++;
                $display("[TB] FAIL refresh interval: got %0d cycles expected 1000..1100", iv);
            end
        end
        waitFrames(7, 300);
        checkOutput("refresh drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while in WAIT_DONE
        led_count      = 3'd4;
        ser_skip_reads = 1'b1;
        ser_hold       = 40;
        commitFrame();
        waitBusy(50);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset drv_start", 32'(drv_start), 32'd0);
        checkOutput("async reset led_count", 32'(drv_led_count), 32'd0);
        checkOutput("async reset frame_count", 32'(frame_count), 32'd0);
        checkOutput("async reset pending", 32'(pending), 32'd0);
        checkOutput("async reset colours", 32'({drv_green, drv_red, drv_blue}), 32'd0);
        @(negedge clk);
        reset_n        = 1'b1;
        ser_skip_reads = 1'b0;
        ser_hold       = 4;
        s0 = start_pulses;
        repeat (1200) @(negedge clk);
        checkOutput("no start after reset", 32'(start_pulses - s0), 32'd0);
        checkOutput("frame_count after reset", 32'(frame_count), 32'd0);

        // New commit after reset: front 0 -> 1, bank 1 still holds set C
        led_count = 3'd1;
        exp_q.push_back(set_c[0]);
        commitFrame();
        waitFrames(1, 200);
        checkOutput("start after recommit", 32'(start_pulses - s0), 32'd1);
        checkOutput("recommit drained", 32'(exp_q.size()), 32'd0);

`ifdef WS2812_FRAME_CTRL_BRIGHTNESS_EN
        // Brightness 127 on 0xFF8040 -> G=0x7F R=0x40 B=0x20
        applyStimulus(3'd0, 24'hFF8040);
        brightness = 8'd127;
        exp_q.push_back(24'h7F4020);
        commitFrame();
        waitFrames(2, 200);
        checkOutput("brightness drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
